// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall.
// Define OPERAND_FWD_EN to enable MEM/WB forwarding into EX; otherwise RAW hazards stall.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic                      i_id_valid,
  input  logic [DATA_WIDTH-1:0]     i_id_pc,
  input  logic [DATA_WIDTH-1:0]     i_id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     i_id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     i_id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
  input  logic [SEL_WIDTH-1:0]      i_id_alu_sel,
  input  logic                      i_id_src_a_pc,
  input  logic                      i_id_src_b_imm,
  input  logic                      i_id_reg_write,
  input  logic                      i_id_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd_addr,
  input  logic                      i_mem_reg_write,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd_addr,
  input  logic                      i_wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     i_wb_data,
  output logic                      o_stall_id,
  output logic                      o_ex_valid,
  output logic [DATA_WIDTH-1:0]     o_alu_src_a,
  output logic [DATA_WIDTH-1:0]     o_alu_src_b,
  output logic [SEL_WIDTH-1:0]      o_alu_sel,
  output logic [DATA_WIDTH-1:0]     o_ex_store_data,
  output logic [DATA_WIDTH-1:0]     o_ex_pc,
  output logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr,
  output logic                      o_ex_reg_write,
  output logic                      o_ex_mem_read
);

  logic                      ex_valid_q;
  logic [DATA_WIDTH-1:0]     ex_pc_q;
  logic [DATA_WIDTH-1:0]     ex_rs1_data_q;
  logic [DATA_WIDTH-1:0]     ex_rs2_data_q;
  logic [DATA_WIDTH-1:0]     ex_imm_q;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_q;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_q;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_q;
  logic [SEL_WIDTH-1:0]      ex_alu_sel_q;
  logic                      ex_src_a_pc_q;
  logic                      ex_src_b_imm_q;
  logic                      ex_reg_write_q;
  logic                      ex_mem_read_q;

  logic                      load_use;
  logic                      hazard;
  logic                      bubble;
  logic [DATA_WIDTH-1:0]     cap_rs1;
  logic [DATA_WIDTH-1:0]     cap_rs2;
  logic [DATA_WIDTH-1:0]     fwd_rs1;
  logic [DATA_WIDTH-1:0]     fwd_rs2;

  assign load_use = ex_valid_q & ex_mem_read_q & (ex_rd_addr_q != '0) & i_id_valid &
                    ((i_id_rs1_addr == ex_rd_addr_q) | (i_id_rs2_addr == ex_rd_addr_q));

`ifdef OPERAND_FWD_EN
  assign hazard = load_use;
`else
  // Without forwarding, any in-flight producer of an ID source must drain first.
  logic rs1_dep;
  logic rs2_dep;
  assign rs1_dep = (i_id_rs1_addr != '0) &
                   ((ex_reg_write_q & (i_id_rs1_addr == ex_rd_addr_q)) |
                    (i_mem_reg_write & (i_id_rs1_addr == i_mem_rd_addr)));
  assign rs2_dep = (i_id_rs2_addr != '0) &
                   ((ex_reg_write_q & (i_id_rs2_addr == ex_rd_addr_q)) |
                    (i_mem_reg_write & (i_id_rs2_addr == i_mem_rd_addr)));
  assign hazard  = load_use | (i_id_valid & (rs1_dep | rs2_dep));
`endif

  assign o_stall_id = i_rst_n & hazard & ~i_flush;
  assign bubble     = i_flush | hazard;

  // WB writes the regfile this same cycle, so the read port still shows stale data.
  assign cap_rs1 = (i_wb_reg_write && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_id_rs1_addr))
                   ? i_wb_data : i_id_rs1_data;
  assign cap_rs2 = (i_wb_reg_write && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_id_rs2_addr))
                   ? i_wb_data : i_id_rs2_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_imm_q       <= '0;
      ex_rs1_addr_q  <= '0;
      ex_rs2_addr_q  <= '0;
      ex_rd_addr_q   <= '0;
      ex_alu_sel_q   <= '0;
      ex_src_a_pc_q  <= 1'b0;
      ex_src_b_imm_q <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
    end else begin
      ex_pc_q        <= i_id_pc;
      ex_rs1_data_q  <= cap_rs1;
      ex_rs2_data_q  <= cap_rs2;
      ex_imm_q       <= i_id_imm;
      ex_rs1_addr_q  <= i_id_rs1_addr;
      ex_rs2_addr_q  <= i_id_rs2_addr;
      ex_rd_addr_q   <= i_id_rd_addr;
      ex_src_a_pc_q  <= i_id_src_a_pc;
      ex_src_b_imm_q <= i_id_src_b_imm;
      if (bubble) begin
        ex_valid_q     <= 1'b0;
        ex_reg_write_q <= 1'b0;
        ex_mem_read_q  <= 1'b0;
        ex_alu_sel_q   <= '0;
      end else begin
        ex_valid_q     <= i_id_valid;
        ex_reg_write_q <= i_id_reg_write;
        ex_mem_read_q  <= i_id_mem_read;
        ex_alu_sel_q   <= i_id_alu_sel;
      end
    end
  end

`ifdef OPERAND_FWD_EN
  always_comb begin
    fwd_rs1 = ex_rs1_data_q;
    if (i_mem_reg_write && (i_mem_rd_addr != '0) && (i_mem_rd_addr == ex_rs1_addr_q))
      fwd_rs1 = i_mem_data;
    else if (i_wb_reg_write && (i_wb_rd_addr != '0) && (i_wb_rd_addr == ex_rs1_addr_q))
      fwd_rs1 = i_wb_data;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data_q;
    if (i_mem_reg_write && (i_mem_rd_addr != '0) && (i_mem_rd_addr == ex_rs2_addr_q))
      fwd_rs2 = i_mem_data;
    else if (i_wb_reg_write && (i_wb_rd_addr != '0) && (i_wb_rd_addr == ex_rs2_addr_q))
      fwd_rs2 = i_wb_data;
  end
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{i_mem_data, ex_rs1_addr_q, ex_rs2_addr_q};
  assign fwd_rs1 = ex_rs1_data_q;
  assign fwd_rs2 = ex_rs2_data_q;
`endif

  assign o_ex_valid      = ex_valid_q;
  assign o_alu_src_a     = ex_src_a_pc_q ? ex_pc_q : fwd_rs1;
  assign o_alu_src_b     = ex_src_b_imm_q ? ex_imm_q : fwd_rs2;
  assign o_alu_sel       = ex_alu_sel_q;
  assign o_ex_store_data = fwd_rs2;
  assign o_ex_pc         = ex_pc_q;
  assign o_ex_rd_addr    = ex_rd_addr_q;
  assign o_ex_reg_write  = ex_reg_write_q;
  assign o_ex_mem_read   = ex_mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - Self-checking bench for id_ex_stage (vectors, corner sequences, random vs model).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_sel;
  logic        id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_data, wb_data;
  logic        stall_id, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] alu_src_a, alu_src_b, ex_store_data, ex_pc;
  logic [3:0]  alu_sel;
  logic [4:0]  ex_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_id_valid(id_valid),
    .i_id_pc(id_pc), .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data),
    .i_id_imm(id_imm), .i_id_rs1_addr(id_rs1_addr), .i_id_rs2_addr(id_rs2_addr),
    .i_id_rd_addr(id_rd_addr), .i_id_alu_sel(id_alu_sel), .i_id_src_a_pc(id_src_a_pc),
    .i_id_src_b_imm(id_src_b_imm), .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
    .i_mem_rd_addr(mem_rd_addr), .i_mem_reg_write(mem_reg_write), .i_mem_data(mem_data),
    .i_wb_rd_addr(wb_rd_addr), .i_wb_reg_write(wb_reg_write), .i_wb_data(wb_data),
    .o_stall_id(stall_id), .o_ex_valid(ex_valid), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_alu_sel(alu_sel), .o_ex_store_data(ex_store_data),
    .o_ex_pc(ex_pc), .o_ex_rd_addr(ex_rd_addr), .o_ex_reg_write(ex_reg_write),
    .o_ex_mem_read(ex_mem_read)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_sel = 0;
    id_src_a_pc = 0; id_src_b_imm = 0; id_reg_write = 0; id_mem_read = 0;
    mem_rd_addr = 0; mem_reg_write = 0; mem_data = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  // Reference model: the instruction sitting in EX, as an architectural record.
  typedef struct {
    logic        valid, a_pc, b_imm, rw, mr;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [3:0]  sel;
  } ex_t;
  ex_t m;

  function automatic logic [31:0] reg_value(input logic [4:0] a, input logic [31:0] held);
`ifdef OPERAND_FWD_EN
    if (mem_reg_write && mem_rd_addr != 0 && mem_rd_addr == a) return mem_data;
    if (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == a) return wb_data;
`endif
    return held;
  endfunction

  function automatic logic reads(input logic [4:0] r);
    return id_valid && r != 0 && (id_rs1_addr == r || id_rs2_addr == r);
  endfunction

  function automatic logic model_hazard();
    logic h;
    h = m.valid && m.mr && reads(m.rd);
`ifndef OPERAND_FWD_EN
    if (m.rw && reads(m.rd)) h = 1;
    if (mem_reg_write && reads(mem_rd_addr)) h = 1;
`endif
    return h;
  endfunction

  task automatic model_capture();
    logic bub;
    if (!rst_n) begin
      m = '{default: '0};
      return;
    end
    bub    = flush || model_hazard();
    m.pc   = id_pc;   m.imm = id_imm;  m.a_pc = id_src_a_pc; m.b_imm = id_src_b_imm;
    m.rs1a = id_rs1_addr; m.rs2a = id_rs2_addr; m.rd = id_rd_addr;
    m.rs1v = (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == id_rs1_addr) ? wb_data : id_rs1_data;
    m.rs2v = (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == id_rs2_addr) ? wb_data : id_rs2_data;
    m.valid = bub ? 1'b0 : id_valid;
    m.rw    = bub ? 1'b0 : id_reg_write;
    m.mr    = bub ? 1'b0 : id_mem_read;
    m.sel   = bub ? 4'd0 : id_alu_sel;
  endtask

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [3:0]  sel;
    logic        a_pc, b_imm;
    logic [4:0]  rs2a;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_d;
    logic [31:0] exp_a, exp_b, exp_st;
  } vec_t;
  vec_t vecs[8];

  logic [31:0] exp_fwd;

  initial begin
    vecs[0] = '{32'h100, 32'd5,    32'd7,    32'h0,        4'd0, 0, 0, 5'd2, 0, 5'd0, 32'h0,    32'd5,    32'd7,        32'd7};
    vecs[1] = '{32'h104, 32'h10,   32'h20,   32'hFFFF_FFFC, 4'd9, 0, 1, 5'd2, 0, 5'd0, 32'h0,    32'h10,   32'hFFFF_FFFC, 32'h20};
    vecs[2] = '{32'h400, 32'd3,    32'h33,   32'd8,        4'd2, 1, 1, 5'd2, 0, 5'd0, 32'h0,    32'h400,  32'd8,        32'h33};
    vecs[3] = '{32'h108, 32'd0,    32'h1,    32'h0,        4'd1, 0, 0, 5'd9, 1, 5'd9, 32'h55,   32'd0,    32'h55,       32'h55};
    vecs[4] = '{32'h10C, 32'd0,    32'h1,    32'h0,        4'd1, 0, 0, 5'd9, 1, 5'd0, 32'h55,   32'd0,    32'h1,        32'h1};
    vecs[5] = '{32'h110, 32'd0,    32'h1,    32'h0,        4'd3, 0, 0, 5'd0, 1, 5'd0, 32'h55,   32'd0,    32'h1,        32'h1};
    vecs[6] = '{32'h114, 32'd0,    32'h1,    32'h0,        4'd4, 0, 0, 5'd9, 0, 5'd9, 32'h55,   32'd0,    32'h1,        32'h1};
    vecs[7] = '{32'h118, 32'h77,   32'h2,    32'h0,        4'd5, 0, 0, 5'd2, 1, 5'd1, 32'hCAFE, 32'hCAFE, 32'h2,        32'h2};

    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Reset while a load-use condition is present, with inputs toggling.
    @(negedge clk);
    id_valid = 1; id_rd_addr = 4; id_mem_read = 1; id_reg_write = 1; id_alu_sel = 4'd7;
    @(negedge clk);
    id_rd_addr = 5; id_rs1_addr = 4; id_mem_read = 0;
    rst_n = 0;
    #1 chk("reset_stall_forced_low", 32'(stall_id), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      id_valid = 1; id_alu_sel = 4'($urandom_range(1, 9)); id_mem_read = 1; id_reg_write = 1;
      id_rd_addr = 5'($urandom_range(1, 3)); id_rs1_addr = id_rd_addr; flush = 1'($urandom);
      #1;
      chk("reset_valid", 32'(ex_valid), 0);
      chk("reset_sel", 32'(alu_sel), 0);
      chk("reset_stall", 32'(stall_id), 0);
      chk("reset_mem_read", 32'(ex_mem_read), 0);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;

    // Table-driven single-cycle captures.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs();
      id_valid = 1; id_pc = vecs[i].pc; id_rs1_data = vecs[i].rs1d; id_rs2_data = vecs[i].rs2d;
      id_imm = vecs[i].imm; id_alu_sel = vecs[i].sel; id_src_a_pc = vecs[i].a_pc;
      id_src_b_imm = vecs[i].b_imm; id_rs1_addr = 5'd1; id_rs2_addr = vecs[i].rs2a;
      wb_reg_write = vecs[i].wb_rw; wb_rd_addr = vecs[i].wb_rd; wb_data = vecs[i].wb_d;
      @(posedge clk);
      #1;
      wb_reg_write = 0;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 1);
      chk($sformatf("vec%0d_src_a", i), alu_src_a, vecs[i].exp_a);
      chk($sformatf("vec%0d_src_b", i), alu_src_b, vecs[i].exp_b);
      chk($sformatf("vec%0d_store", i), ex_store_data, vecs[i].exp_st);
      chk($sformatf("vec%0d_sel", i), 32'(alu_sel), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_pc", i), ex_pc, vecs[i].pc);
    end

    // Forwarding priority from the latched rs1 address.
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rs1_addr = 3; id_rs1_data = 32'h11;
    @(posedge clk);
    #1;
    id_valid = 0;
    mem_reg_write = 1; mem_rd_addr = 3; mem_data = 32'hAA;
    wb_reg_write = 1; wb_rd_addr = 3; wb_data = 32'hBB;
`ifdef OPERAND_FWD_EN
    exp_fwd = 32'hAA;
`else
    exp_fwd = 32'h11;
`endif
    #1 chk("fwd_mem_over_wb", alu_src_a, exp_fwd);
    mem_rd_addr = 0;
`ifdef OPERAND_FWD_EN
    exp_fwd = 32'hBB;
`endif
    #1 chk("fwd_wb_when_mem_x0", alu_src_a, exp_fwd);
    mem_reg_write = 0; wb_reg_write = 0;
    #1 chk("fwd_none", alu_src_a, 32'h11);

    // Load-use: one stall cycle, one bubble, then the consumer proceeds.
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rd_addr = 4; id_mem_read = 1; id_reg_write = 1;
    @(negedge clk);
    id_rd_addr = 5; id_rs1_addr = 4; id_rs2_addr = 1; id_mem_read = 0; id_alu_sel = 4'd3;
    #1;
    chk("lu_stall", 32'(stall_id), 1);
    chk("lu_ex_is_load", 32'(ex_mem_read), 1);
    @(posedge clk);
    #1;
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_sel", 32'(alu_sel), 0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 0);
    chk("lu_stall_released", 32'(stall_id), 0);
    @(posedge clk);
    #1;
    chk("lu_add_valid", 32'(ex_valid), 1);
    chk("lu_add_rd", 32'(ex_rd_addr), 5);
    chk("lu_add_sel", 32'(alu_sel), 3);
    chk("lu_no_stall", 32'(stall_id), 0);

    // Flush wins over a pending load-use hazard.
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rd_addr = 4; id_mem_read = 1; id_reg_write = 1;
    @(negedge clk);
    id_rd_addr = 5; id_rs1_addr = 0; id_rs2_addr = 4; id_mem_read = 0; id_alu_sel = 4'd2;
    flush = 1;
    #1 chk("flush_stall_low", 32'(stall_id), 0);
    @(posedge clk);
    #1;
    chk("flush_bubble_valid", 32'(ex_valid), 0);
    chk("flush_bubble_rw", 32'(ex_reg_write), 0);
    chk("flush_bubble_sel", 32'(alu_sel), 0);

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n         = (c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      flush         = ($urandom_range(0, 7) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_pc         = $urandom;  id_rs1_data = $urandom;  id_rs2_data = $urandom;
      id_imm        = $urandom;
      id_rs1_addr   = 5'($urandom_range(0, 3));
      id_rs2_addr   = 5'($urandom_range(0, 3));
      id_rd_addr    = 5'($urandom_range(0, 3));
      id_alu_sel    = 4'($urandom_range(0, 9));
      id_src_a_pc   = 1'($urandom);  id_src_b_imm = 1'($urandom);
      id_reg_write  = 1'($urandom);
      id_mem_read   = ($urandom_range(0, 2) == 0);
      mem_rd_addr   = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom);  mem_data = $urandom;
      wb_rd_addr    = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom);  wb_data = $urandom;
      #1;
      if (c > 0) begin
        chk("rnd_stall", 32'(stall_id), 32'(rst_n && !flush && model_hazard()));
        chk("rnd_valid", 32'(ex_valid), 32'(m.valid));
        chk("rnd_sel", 32'(alu_sel), 32'(m.sel));
        chk("rnd_reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("rnd_mem_read", 32'(ex_mem_read), 32'(m.mr));
        if (m.valid) begin
          chk("rnd_src_a", alu_src_a, m.a_pc ? m.pc : reg_value(m.rs1a, m.rs1v));
          chk("rnd_src_b", alu_src_b, m.b_imm ? m.imm : reg_value(m.rs2a, m.rs2v));
          chk("rnd_store", ex_store_data, reg_value(m.rs2a, m.rs2v));
          chk("rnd_pc", ex_pc, m.pc);
          chk("rnd_rd", 32'(ex_rd_addr), 32'(m.rd));
        end
      end
      model_capture();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
